// File: rtl/audio_mix_seq.sv
// Register-controlled NCH-channel stereo mixer: snapshots a frame on sample_i,
// accumulates one channel per clock on a shared L/R multiplier pair, saturates.
module audio_mix_seq #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int GW  = 8,
  parameter int AW  = 4,
  parameter logic [GW-1:0] GAIN_RST = GW'(8'h20)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*W-1:0]  l_in,
  input  logic [NCH*W-1:0]  r_in,
  input  logic              sample_i,
  output logic [W-1:0]      l_out,
  output logic [W-1:0]      r_out,
  output logic              out_strobe,
  output logic              busy,
  input  logic [AW-1:0]     reg_addr,
  input  logic [7:0]        reg_wdata,
  input  logic              reg_we,
  output logic [7:0]        reg_rdata
);

  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = W + GW + 1;
  localparam int ACCW = PW + $clog2(NCH);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic signed [ACCW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NCH*W-1:0]       sl_q, sl_d, sr_q, sr_d;
  logic [GW-1:0]          sgl_q [NCH];
  logic [GW-1:0]          sgl_d [NCH];
  logic [GW-1:0]          sgr_q [NCH];
  logic [GW-1:0]          sgr_d [NCH];
  logic                   smute_q, smute_d;
  logic [GW-1:0]          gl_q [NCH];
  logic [GW-1:0]          gl_d [NCH];
  logic [GW-1:0]          gr_q [NCH];
  logic [GW-1:0]          gr_d [NCH];
  logic                   mute_q, mute_d;
  logic                   clipl_q, clipl_d, clipr_q, clipr_d, ovr_q, ovr_d;
  logic [W-1:0]           l_out_q, l_out_d, r_out_q, r_out_d;
  logic                   strobe_q, strobe_d;
  logic [7:0]             rdata_q, rdata_d;

  logic signed [PW-1:0]   samp_l, samp_r, gain_l, gain_r, prod_l, prod_r;
  logic [W:0]             sat_l, sat_r;

  // Returns {clipped, saturated value} of acc >>> (GW-1)
  function automatic logic [W:0] saturate(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] s;
    s = acc >>> (GW - 1);
    if (s > SMAX)      return {1'b1, 1'b0, {(W-1){1'b1}}};
    else if (s < SMIN) return {1'b1, 1'b1, {(W-1){1'b0}}};
    else               return {1'b0, s[W-1:0]};
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    sl_d     = sl_q;
    sr_d     = sr_q;
    sgl_d    = sgl_q;
    sgr_d    = sgr_q;
    smute_d  = smute_q;
    gl_d     = gl_q;
    gr_d     = gr_q;
    mute_d   = mute_q;
    clipl_d  = clipl_q;
    clipr_d  = clipr_q;
    ovr_d    = ovr_q;
    l_out_d  = l_out_q;
    r_out_d  = r_out_q;
    strobe_d = 1'b0;
    rdata_d  = '0;

    samp_l = PW'($signed(sl_q[int'(idx_q)*W +: W]));
    samp_r = PW'($signed(sr_q[int'(idx_q)*W +: W]));
    gain_l = PW'({1'b0, sgl_q[idx_q]});
    gain_r = PW'({1'b0, sgr_q[idx_q]});
    prod_l = samp_l * gain_l;
    prod_r = samp_r * gain_r;
    sat_l  = saturate(acc_l_q);
    sat_r  = saturate(acc_r_q);

    if (reg_we) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (reg_addr == AW'(c))       gl_d[c] = GW'(reg_wdata);
        if (reg_addr == AW'(NCH + c)) gr_d[c] = GW'(reg_wdata);
      end
      if (reg_addr == AW'(2 * NCH)) begin
        mute_d = reg_wdata[0];
        if (reg_wdata[1]) begin
          clipl_d = 1'b0;
          clipr_d = 1'b0;
          ovr_d   = 1'b0;
        end
      end
    end

    // FSM flag sets come after the CTRL clear so that a same-cycle set wins
    unique case (state_q)
      IDLE: begin
        if (sample_i) begin
          sl_d    = l_in;
          sr_d    = r_in;
          sgl_d   = gl_q;
          sgr_d   = gr_q;
          smute_d = mute_q;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_l_d = acc_l_q + ACCW'(prod_l);
        acc_r_d = acc_r_q + ACCW'(prod_r);
        if (idx_q == LAST) state_d = OUT;
        else               idx_d   = idx_q + 1'b1;
        if (sample_i) ovr_d = 1'b1;
      end
      OUT: begin
        l_out_d  = smute_q ? '0 : sat_l[W-1:0];
        r_out_d  = smute_q ? '0 : sat_r[W-1:0];
        if (sat_l[W]) clipl_d = 1'b1;
        if (sat_r[W]) clipr_d = 1'b1;
        strobe_d = 1'b1;
        state_d  = IDLE;
        if (sample_i) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned c = 0; c < NCH; c++) begin
      if (reg_addr == AW'(c))       rdata_d = 8'(gl_q[c]);
      if (reg_addr == AW'(NCH + c)) rdata_d = 8'(gr_q[c]);
    end
    if (reg_addr == AW'(2 * NCH)) rdata_d = {4'b0, ovr_q, clipr_q, clipl_q, mute_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      sl_q     <= '0;
      sr_q     <= '0;
      sgl_q    <= '{default: '0};
      sgr_q    <= '{default: '0};
      smute_q  <= 1'b0;
      gl_q     <= '{default: GAIN_RST};
      gr_q     <= '{default: GAIN_RST};
      mute_q   <= 1'b0;
      clipl_q  <= 1'b0;
      clipr_q  <= 1'b0;
      ovr_q    <= 1'b0;
      l_out_q  <= '0;
      r_out_q  <= '0;
      strobe_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      sgl_q    <= sgl_d;
      sgr_q    <= sgr_d;
      smute_q  <= smute_d;
      gl_q     <= gl_d;
      gr_q     <= gr_d;
      mute_q   <= mute_d;
      clipl_q  <= clipl_d;
      clipr_q  <= clipr_d;
      ovr_q    <= ovr_d;
      l_out_q  <= l_out_d;
      r_out_q  <= r_out_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
    end
  end

  assign l_out      = l_out_q;
  assign r_out      = r_out_q;
  assign out_strobe = strobe_q;
  assign busy       = (state_q != IDLE);
  assign reg_rdata  = rdata_q;

endmodule

// File: tb/tb_audio_mix_seq.sv
// Directed bench for audio_mix_seq: hand-computed mix results, register map,
// overrun, snapshot isolation, saturation and reset abort.
module tb_audio_mix_seq;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int GW  = 8;
  localparam int AW  = 4;
  localparam logic [AW-1:0] CTRL = AW'(2 * NCH);

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH*W-1:0] l_in, r_in;
  logic             sample_i;
  logic [W-1:0]     l_out, r_out;
  logic             out_strobe, busy;
  logic [AW-1:0]    reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_we;
  logic [7:0]       reg_rdata;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  audio_mix_seq #(.NCH(NCH), .W(W), .GW(GW), .AW(AW), .GAIN_RST(8'h20)) dut (
    .clk(clk), .reset(reset), .l_in(l_in), .r_in(r_in), .sample_i(sample_i),
    .l_out(l_out), .r_out(r_out), .out_strobe(out_strobe), .busy(busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    step();
    reg_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    reg_addr = a;
    step();
    chk(tag, reg_rdata, exp);
  endtask

  task automatic set_in(input logic [W-1:0] l, input logic [W-1:0] r);
    for (int ch = 0; ch < NCH; ch++) begin
      l_in[ch*W +: W] = l;
      r_in[ch*W +: W] = r;
    end
  endtask

  task automatic set_gains(input logic [7:0] g);
    for (int a = 0; a < 2 * NCH; a++) wr(AW'(a), g);
  endtask

  task automatic pulse();
    sample_i = 1'b1;
    step();
    sample_i = 1'b0;
  endtask

  // Returns at the negedge where out_strobe is seen; latency in cycles since call
  task automatic wait_strobe(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_strobe) begin
        lat = i;
        break;
      end
    end
    chk(tag, lat, exp_lat);
  endtask

  task automatic frame(input string tag, input logic [W-1:0] el, input logic [W-1:0] er);
    pulse();
    chk({tag, "_busy"}, busy, 1);
    wait_strobe({tag, "_lat"}, NCH + 1);
    chk({tag, "_busy_at_strobe"}, busy, 0);
    chk({tag, "_l"}, l_out, el);
    chk({tag, "_r"}, r_out, er);
    step();
    chk({tag, "_strobe_1cyc"}, out_strobe, 0);
  endtask

  task automatic count_strobes(input string tag, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      step();
      if (out_strobe) n++;
    end
    chk(tag, n, 0);
  endtask

  initial begin
    reset = 1'b1; sample_i = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    set_in('0, '0);
    repeat (3) step();
    chk("rst_l", l_out, 0);
    chk("rst_r", r_out, 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", reg_rdata, 0);
    reset = 1'b0;

    rd_chk("gl0_rst", 0, 8'h20);
    rd_chk("gr1_rst", AW'(NCH + 1), 8'h20);
    rd_chk("ctrl_rst", CTRL, 8'h00);
    wr(9, 8'hFF);
    rd_chk("unmapped9", 9, 8'h00);
    rd_chk("unmapped15", 15, 8'h00);

    // Default gains 0x20 x 4 channels x 0x4000 -> 0x4000
    set_in(16'h4000, 16'h4000);
    frame("dflt", 16'h4000, 16'h4000);
    wr(CTRL, 8'h01);
    rd_chk("ctrl_mute", CTRL, 8'h01);
    frame("mute", 16'h0000, 16'h0000);
    wr(CTRL, 8'h00);

    // Unity pass-through on channel 0 only
    set_gains(8'h00);
    wr(0, 8'h80);
    wr(AW'(NCH), 8'h80);
    rd_chk("gr0_rb", AW'(NCH), 8'h80);
    set_in(16'h7777, 16'h8888);
    l_in[0 +: W] = 16'h1234;
    r_in[0 +: W] = 16'hEDCC;
    frame("unity", 16'h1234, 16'hEDCC);

    // Gain write during ACC must not affect the running frame
    pulse();
    wr(0, 8'h00);
    wait_strobe("snap_lat", NCH);
    chk("snap_l", l_out, 16'h1234);
    step();
    frame("snap2", 16'h0000, 16'hEDCC);
    wr(0, 8'h80);

    // Overrun: second pulse two cycles after the first is dropped
    pulse();
    step();
    pulse();
    wait_strobe("ovr_lat", NCH + 1 - 2);
    chk("ovr_l", l_out, 16'h1234);
    count_strobes("ovr_single", 10);
    rd_chk("ctrl_ovr", CTRL, 8'h08);
    wr(CTRL, 8'h02);
    rd_chk("ctrl_clr1", CTRL, 8'h00);

    // sample_i coincident with out_strobe is accepted without OVR
    pulse();
    wait_strobe("coin_lat1", NCH + 1);
    l_in[0 +: W] = 16'h0042;
    pulse();
    wait_strobe("coin_lat2", NCH + 1);
    chk("coin_l", l_out, 16'h0042);
    rd_chk("ctrl_coin", CTRL, 8'h00);

    // Saturation both directions
    set_gains(8'hFF);
    set_in(16'h7FFF, 16'h7FFF);
    frame("satp", 16'h7FFF, 16'h7FFF);
    rd_chk("ctrl_clip", CTRL, 8'h06);
    set_in(16'h8000, 16'h8000);
    frame("satn", 16'h8000, 16'h8000);
    wr(CTRL, 8'h02);
    rd_chk("ctrl_clr2", CTRL, 8'h00);
    set_in(16'h7FFF, 16'h7FFF);
    frame("satp2", 16'h7FFF, 16'h7FFF);
    wr(CTRL, 8'h01);
    rd_chk("ctrl_mute_clip", CTRL, 8'h07);

    // Reset mid-ACC aborts the frame and restores defaults
    pulse();
    step();
    reset = 1'b1;
    step();
    chk("abort_l", l_out, 0);
    chk("abort_r", r_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_strobe", out_strobe, 0);
    chk("abort_rdata", reg_rdata, 0);
    reset = 1'b0;
    count_strobes("abort_nostrobe", 10);
    rd_chk("gl0_rst2", 0, 8'h20);
    rd_chk("gr3_rst2", AW'(NCH + 3), 8'h20);
    rd_chk("ctrl_rst2", CTRL, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/audio_mix_seq.md
# audio_mix_seq

Parametrised, register-controlled stereo mixer for the AURA audio path; replaces the fixed ½+½ two-source sum between the source decoders (OPM, VERA I2S decoder, future sources) and the I2S encoder. On each sample strobe it snapshots NCH stereo inputs and their per-channel gains, then accumulates them one channel per clock on a shared left/right multiplier pair. It saturates the result and presents it with an output strobe. The gains, mute and sticky status flags are accessible through a small byte-wide register port driven from the I/O-bus decode.

## Interface
- NCH, 4: number of stereo input channels, 2..8
- W, 16: signed sample width
- GW, 8: unsigned gain width; unity = 2^(GW-1)
- AW, 4: register address width; 2^AW ≥ 2·NCH+1
- GAIN_RST, 8'h20: reset value of every gain register
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- l_in  in  NCH·W  left samples, channel c at [c·W +: W], signed
- r_in  in  NCH·W  right samples, same packing
- sample_i  in  1  one-cycle pulse: new input frame valid
- l_out  out  W  mixed left sample, signed
- r_out  out  W  mixed right sample, signed
- out_strobe  out  1  one-cycle pulse: l_out/r_out updated
- busy  out  1  frame computation in progress
- reg_addr  in  AW  register address
- reg_wdata  in  8  write data
- reg_we  in  1  write enable, one cycle per write
- reg_rdata  out  8  read data for reg_addr, registered

## Operation
- Register map:
  - addr c (0..NCH-1) = left gain c
  - NCH+c = right gain c
  - 2·NCH = CTRL
  - other addresses: writes ignored, read 0
- CTRL write: bit0 MUTE is stored; bit1 = 1 clears all sticky flags. Bit1 is an action bit and is not stored.
- CTRL read: {4'b0, OVR, CLIPR, CLIPL, MUTE}.
- When GW > 8, gain registers use reg_wdata zero-extended. The read returns the low 8 bits.
- States: IDLE, ACC, OUT.
- IDLE:
  - sample_i → capture l_in, r_in, all gains and MUTE into snapshot registers.
  - Clear both accumulators, set channel index to 0, go to ACC.
- ACC:
  - Each cycle: accL += sL[i]·gL[i] and accR += sR[i]·gR[i], as signed × zero-extended-unsigned products.
  - Increment i. After channel NCH-1, go to OUT.
- OUT:
  - Compute s = acc >>> (GW-1), arithmetic shift (truncation toward −∞).
  - Saturate s to [−2^(W-1), 2^(W-1)−1].
  - If the snapshot MUTE is set, the value is 0.
  - Register l_out/r_out, pulse out_strobe, return to IDLE.
  - Saturation sets the sticky CLIPL/CLIPR flag, even when muted.
- Accumulator width: W+GW+1+ceil(log2 NCH). No internal overflow is permitted.
- sample_i while busy (ACC or OUT): frame dropped, OVR set, computation unaffected.
- Register writes take effect immediately in the register file. A running frame uses its snapshot, so writes during ACC affect only the next frame.
- Same-cycle flag clear and flag set: set wins.
- reset:
  - Applies from any state: go to IDLE and abort any frame in progress; no out_strobe.
  - Gains = GAIN_RST, MUTE = 0, flags = 0.
  - l_out = r_out = 0, out_strobe = 0, busy = 0, reg_rdata = 0.

## Timing
- sample_i sampled at edge k. ACC occupies edges k+1..k+NCH. OUT result is registered at edge k+NCH+1.
- out_strobe is high for exactly the one cycle after edge k+NCH+1. Latency is NCH+1 clocks.
- l_out/r_out hold their value until the next out_strobe.
- busy is high from edge k to edge k+NCH+1. It is low in the cycle out_strobe is high, so a sample_i coincident with out_strobe is accepted.
- Minimum frame spacing: NCH+1 clocks. At 25 MHz and a 48.8 kHz frame rate, the margin is large.
- reg_rdata is the value at reg_addr registered at each edge: 1-cycle read latency. A write is visible on read-back one cycle after the write edge.

## Test plan
- Reset check:
  - Assert reset mid-ACC → no out_strobe; outputs, flags and busy are 0.
  - Gain registers read 0x20; CTRL reads 0x00.
- Unity pass-through: gL[0]=gR[0]=0x80, others 0; l_in ch0 = 0x1234, r_in ch0 = 0xEDCC; pulse sample_i → after NCH+1 clocks, l_out = 0x1234, r_out = 0xEDCC, one-cycle strobe.
- Saturation: all gains 0xFF, all inputs 0x7FFF → l_out = 0x7FFF, CLIPL=1. Then all inputs 0x8000 → l_out = 0x8000.
  - Write CTRL = 0x02 → CTRL reads 0x00.
- Overrun: sample_i at cycles 0 and 2 → a single out_strobe at cycle NCH+1, OVR = 1. Sample_i coinciding with out_strobe → accepted, OVR unchanged.
- Snapshot: write gL[0] = 0x00 during ACC of a unity frame → that frame's output uses 0x80 and the next frame outputs 0.
- Mute/default mix: reset gains, NCH=4, all inputs 0x4000 → l_out = 0x4000. With MUTE=1 → strobe still occurs, l_out = 0.
